cnn3d_conv_pool_engine: RTL and testbench

Parametrised, sequential 3D convolution + max-pooling engine; successor to the fixed 6x6x6 / 3-filter conv+pool top. Image and filter weights are loaded through a write port. A single time-multiplexed MAC computes each conv voxel and folds it into a running max per pool window. Pooled results stream out on a valid/ready port, so the downstream dense layer can apply backpressure.

---
 rtl/cnn3d_conv_pool_engine.sv | 259 +++++++++++++++++++++++++
 tb/tb_cnn3d_conv_pool_engine.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn3d_conv_pool_engine.sv
// rtl/cnn3d_conv_pool_engine.sv - sequential 3D conv + max-pool engine, single time-multiplexed MAC.
// Optional build macro CNN3D_RELU_EN: clamp conv results at zero before pooling.
module cnn3d_conv_pool_engine #(
    parameter int IMG_SIZE    = 6,
    parameter int FILT_SIZE   = 3,
    parameter int NUM_FILTERS = 3,
    parameter int POOL_SIZE   = 2,
    parameter int DATA_W      = 8,
    parameter int ACC_W       = 24,
    parameter int OUT_W       = 16,
    localparam int CONV_SIZE  = IMG_SIZE - FILT_SIZE + 1,
    localparam int POOL_OUT   = CONV_SIZE / POOL_SIZE,
    localparam int IMG_VOX    = IMG_SIZE ** 3,
    localparam int WGT_VOX    = NUM_FILTERS * (FILT_SIZE ** 3),
    localparam int ADDR_W     = $clog2((IMG_VOX > WGT_VOX) ? IMG_VOX : WGT_VOX),
    localparam int FILT_W     = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1,
    localparam int IDX_W      = ((POOL_OUT ** 3) > 1) ? $clog2(POOL_OUT ** 3) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_valid,
    input  logic              ld_sel,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic [FILT_W-1:0] out_filter,
    output logic [IDX_W-1:0]  out_index
);

    localparam int F3    = FILT_SIZE ** 3;
    localparam int IA_W  = (IMG_VOX > 1) ? $clog2(IMG_VOX) : 1;
    localparam int WA_W  = (WGT_VOX > 1) ? $clog2(WGT_VOX) : 1;
    localparam int CW    = $clog2(IMG_SIZE + 1);
    localparam int PO_M1 = (POOL_OUT > 0) ? POOL_OUT - 1 : 0;
    localparam bit EMPTY = (POOL_OUT == 0);

    localparam logic signed [ACC_W-1:0] SAT_HI = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_LO = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
`ifdef CNN3D_RELU_EN
    localparam logic signed [OUT_W-1:0] MAX_INIT = '0;
`else
    localparam logic signed [OUT_W-1:0] MAX_INIT = {1'b1, {(OUT_W-1){1'b0}}};
`endif

    typedef enum logic [2:0] {S_IDLE, S_MAC, S_FOLD, S_OUT, S_DONE} state_t;
    state_t r_state, w_next;

    logic signed [DATA_W-1:0] r_img [IMG_VOX];
    logic signed [DATA_W-1:0] r_wgt [WGT_VOX];

    logic [CW-1:0]            r_kx, r_ky, r_kz, r_dx, r_dy, r_dz, r_px, r_py, r_pz;
    logic [FILT_W-1:0]        r_f;
    logic signed [ACC_W-1:0]  r_acc;
    logic signed [OUT_W-1:0]  r_max;
    logic                     r_out_valid;
    logic signed [OUT_W-1:0]  r_out_data;
    logic [FILT_W-1:0]        r_out_filter;
    logic [IDX_W-1:0]         r_out_index;

    logic                     w_tap_first, w_tap_last, w_win_first, w_win_last, w_all_last;
    logic [IA_W-1:0]          w_ix, w_iy, w_iz, w_img_addr;
    logic [WA_W-1:0]          w_wgt_addr;
    logic signed [DATA_W-1:0] w_pix, w_wgt;
    logic signed [2*DATA_W-1:0] w_prod;
    logic signed [ACC_W-1:0]  w_prod_ext;
    logic signed [OUT_W-1:0]  w_sat, w_fold_val, w_max_base, w_max_new;
    logic [IDX_W-1:0]         w_out_index;

    assign w_tap_first = (r_kx == '0) && (r_ky == '0) && (r_kz == '0);
    assign w_tap_last  = (r_kx == CW'(FILT_SIZE-1)) && (r_ky == CW'(FILT_SIZE-1))
                      && (r_kz == CW'(FILT_SIZE-1));
    assign w_win_first = (r_dx == '0) && (r_dy == '0) && (r_dz == '0);
    assign w_win_last  = (r_dx == CW'(POOL_SIZE-1)) && (r_dy == CW'(POOL_SIZE-1))
                      && (r_dz == CW'(POOL_SIZE-1));
    assign w_all_last  = (r_px == CW'(PO_M1)) && (r_py == CW'(PO_M1)) && (r_pz == CW'(PO_M1))
                      && (r_f == FILT_W'(NUM_FILTERS-1));

    // Image coordinate = pool origin + window offset + kernel tap.
    assign w_ix = IA_W'(r_px) * IA_W'(POOL_SIZE) + IA_W'(r_dx) + IA_W'(r_kx);
    assign w_iy = IA_W'(r_py) * IA_W'(POOL_SIZE) + IA_W'(r_dy) + IA_W'(r_ky);
    assign w_iz = IA_W'(r_pz) * IA_W'(POOL_SIZE) + IA_W'(r_dz) + IA_W'(r_kz);
    assign w_img_addr = w_iz * IA_W'(IMG_SIZE*IMG_SIZE) + w_iy * IA_W'(IMG_SIZE) + w_ix;
    assign w_wgt_addr = WA_W'(r_f) * WA_W'(F3) + WA_W'(r_kz) * WA_W'(FILT_SIZE*FILT_SIZE)
                      + WA_W'(r_ky) * WA_W'(FILT_SIZE) + WA_W'(r_kx);

    assign w_pix      = r_img[w_img_addr];
    assign w_wgt      = r_wgt[w_wgt_addr];
    assign w_prod     = w_pix * w_wgt;
    assign w_prod_ext = {{(ACC_W-2*DATA_W){w_prod[2*DATA_W-1]}}, w_prod};

    always_comb begin
        w_sat = r_acc[OUT_W-1:0];
        if (r_acc > SAT_HI) begin
            w_sat = SAT_HI[OUT_W-1:0];
        end else if (r_acc < SAT_LO) begin
            w_sat = SAT_LO[OUT_W-1:0];
        end
    end

`ifdef CNN3D_RELU_EN
    assign w_fold_val = w_sat[OUT_W-1] ? '0 : w_sat;
`else
    assign w_fold_val = w_sat;
`endif

    assign w_max_base  = w_win_first ? MAX_INIT : r_max;
    assign w_max_new   = (w_fold_val > w_max_base) ? w_fold_val : w_max_base;
    assign w_out_index = IDX_W'(r_pz) * IDX_W'(POOL_OUT*POOL_OUT)
                       + IDX_W'(r_py) * IDX_W'(POOL_OUT) + IDX_W'(r_px);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_MAC;
                end
            end
            S_MAC: begin
                busy = 1'b1;
                if (EMPTY) begin
                    w_next = S_DONE;
                end else if (w_tap_last) begin
                    w_next = S_FOLD;
                end
            end
            S_FOLD: begin
                busy   = 1'b1;
                w_next = w_win_last ? S_OUT : S_MAC;
            end
            S_OUT: begin
                busy = 1'b1;
                if (r_out_valid && out_ready) begin
                    w_next = w_all_last ? S_DONE : S_MAC;
                end
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_kx <= '0; r_ky <= '0; r_kz <= '0;
            r_dx <= '0; r_dy <= '0; r_dz <= '0;
            r_px <= '0; r_py <= '0; r_pz <= '0;
            r_f          <= '0;
            r_acc        <= '0;
            r_max        <= '0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_filter <= '0;
            r_out_index  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_kx <= '0; r_ky <= '0; r_kz <= '0;
                        r_dx <= '0; r_dy <= '0; r_dz <= '0;
                        r_px <= '0; r_py <= '0; r_pz <= '0;
                        r_f  <= '0;
                    end
                end
                S_MAC: begin
                    r_acc <= w_tap_first ? w_prod_ext : r_acc + w_prod_ext;
                    if (r_kx == CW'(FILT_SIZE-1)) begin
                        r_kx <= '0;
                        if (r_ky == CW'(FILT_SIZE-1)) begin
                            r_ky <= '0;
                            r_kz <= (r_kz == CW'(FILT_SIZE-1)) ? '0 : r_kz + CW'(1);
                        end else begin
                            r_ky <= r_ky + CW'(1);
                        end
                    end else begin
                        r_kx <= r_kx + CW'(1);
                    end
                end
                S_FOLD: begin
                    r_max <= w_max_new;
                    if (r_dx == CW'(POOL_SIZE-1)) begin
                        r_dx <= '0;
                        if (r_dy == CW'(POOL_SIZE-1)) begin
                            r_dy <= '0;
                            r_dz <= (r_dz == CW'(POOL_SIZE-1)) ? '0 : r_dz + CW'(1);
                        end else begin
                            r_dy <= r_dy + CW'(1);
                        end
                    end else begin
                        r_dx <= r_dx + CW'(1);
                    end
                end
                S_OUT: begin
                    // First OUT cycle registers the result; the rest hold until accepted.
                    if (!r_out_valid) begin
                        r_out_valid  <= 1'b1;
                        r_out_data   <= r_max;
                        r_out_filter <= r_f;
                        r_out_index  <= w_out_index;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (r_px == CW'(PO_M1)) begin
                            r_px <= '0;
                            if (r_py == CW'(PO_M1)) begin
                                r_py <= '0;
                                if (r_pz == CW'(PO_M1)) begin
                                    r_pz <= '0;
                                    r_f  <= (r_f == FILT_W'(NUM_FILTERS-1)) ? '0 : r_f + FILT_W'(1);
                                end else begin
                                    r_pz <= r_pz + CW'(1);
                                end
                            end else begin
                                r_py <= r_py + CW'(1);
                            end
                        end else begin
                            r_px <= r_px + CW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Memories are deliberately outside the reset domain so contents survive a reset.
    always_ff @(posedge clk) begin
        if (ld_valid && (r_state == S_IDLE)) begin
            if (!ld_sel && (int'(ld_addr) < IMG_VOX)) begin
                r_img[ld_addr[IA_W-1:0]] <= ld_data;
            end
            if (ld_sel && (int'(ld_addr) < WGT_VOX)) begin
                r_wgt[ld_addr[WA_W-1:0]] <= ld_data;
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_filter = r_out_filter;
    assign out_index  = r_out_index;

endmodule

// File: tb/tb_cnn3d_conv_pool_engine.sv
// tb/tb_cnn3d_conv_pool_engine.sv - self-checking bench for cnn3d_conv_pool_engine with a reference model.
module tb_cnn3d_conv_pool_engine;

    localparam int IMG = 6, FILT = 3, NF = 3, POOL = 2, PO = 2;
    localparam int AW = 8, DW = 8, OW = 16;
    localparam int NIMG = IMG*IMG*IMG, NWGT = NF*FILT*FILT*FILT;
    localparam int NWIN = NF*PO*PO*PO, LAT = 225, LIMIT = 20000;
`ifdef CNN3D_RELU_EN
    localparam int NEG27 = 0;
`else
    localparam int NEG27 = -27;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          ld_valid, ld_sel;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;
    logic          start, busy, done, out_valid, out_ready;
    logic [OW-1:0] out_data;
    logic [1:0]    out_filter;
    logic [2:0]    out_index;

    always #5 clk = ~clk;

    cnn3d_conv_pool_engine dut (
        .clk(clk), .reset(reset), .ld_valid(ld_valid), .ld_sel(ld_sel), .ld_addr(ld_addr),
        .ld_data(ld_data), .start(start), .busy(busy), .done(done), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_filter(out_filter), .out_index(out_index)
    );

    int n_checks = 0, n_errors = 0;
    int m_img [NIMG];
    int m_wgt [NWGT];
    int got_data[$], got_filt[$], got_idx[$], exp_data[$];
    int first_valid, done_cnt, busy_at_done, post_busy, post_done, timed_out;
    int stall_bad, stall_samples, snap_data, snap_idx;

    // Reference: conv sum per voxel, saturate, optional ReLU, max over each pool window.
    task automatic build_expected();
        exp_data.delete();
        for (int f = 0; f < NF; f++)
            for (int pz = 0; pz < PO; pz++)
                for (int py = 0; py < PO; py++)
                    for (int px = 0; px < PO; px++) begin
`ifdef CNN3D_RELU_EN
                        int mx = 0;
`else
                        int mx = -32768;
`endif
                        for (int d = 0; d < POOL*POOL*POOL; d++) begin
                            int cz = pz*POOL + d/4, cy = py*POOL + (d/2)%2, cx = px*POOL + d%2;
                            int s = 0;
                            for (int kz = 0; kz < FILT; kz++)
                                for (int ky = 0; ky < FILT; ky++)
                                    for (int kx = 0; kx < FILT; kx++)
                                        s += m_img[(cz+kz)*IMG*IMG + (cy+ky)*IMG + cx+kx]
                                           * m_wgt[f*27 + kz*9 + ky*3 + kx];
                            if (s > 32767) s = 32767;
                            if (s < -32768) s = -32768;
`ifdef CNN3D_RELU_EN
                            if (s < 0) s = 0;
`endif
                            if (s > mx) mx = s;
                        end
                        exp_data.push_back(mx);
                    end
    endtask

    task automatic load_mem(input int skip_last);
        for (int i = 0; i < NIMG; i++) begin
            @(negedge clk);
            ld_valid = 1'b1; ld_sel = 1'b0; ld_addr = AW'(i); ld_data = DW'(m_img[i]);
        end
        for (int i = 0; i < NWGT - skip_last; i++) begin
            @(negedge clk);
            ld_valid = 1'b1; ld_sel = 1'b1; ld_addr = AW'(i); ld_data = DW'(m_wgt[i]);
        end
        @(negedge clk);
        ld_valid = 1'b0;
    endtask

    task automatic run_collect(input int ready_pct, input int stall_n, input int poke_start,
                               input int poke_wr, input bit co_wr, input int co_addr, input int co_data);
        int cyc, stall_left;
        bit fin, rdy;
        got_data.delete(); got_filt.delete(); got_idx.delete();
        first_valid = -1; done_cnt = 0; busy_at_done = -1; timed_out = 0;
        stall_bad = 0; stall_samples = 0; snap_data = 0; snap_idx = 0;
        start = 1'b1; out_ready = 1'b0;
        if (co_wr) begin
            ld_valid = 1'b1; ld_sel = 1'b1; ld_addr = AW'(co_addr); ld_data = DW'(co_data);
        end
        @(negedge clk);
        start = 1'b0; ld_valid = 1'b0;
        cyc = 0; fin = 0; stall_left = 0;
        while (!fin) begin
            @(negedge clk);
            cyc++;
            start = (cyc == poke_start);
            if (cyc == poke_wr) begin
                ld_valid = 1'b1; ld_sel = 1'b0; ld_addr = '0; ld_data = 8'd99;
            end else begin
                ld_valid = 1'b0;
            end
            if (out_valid && first_valid < 0) begin
                first_valid = cyc; stall_left = stall_n;
                snap_data = int'($signed(out_data)); snap_idx = int'(out_index);
            end
            if (out_valid && stall_left > 0) begin
                stall_samples++;
                if (int'($signed(out_data)) != snap_data || int'(out_index) != snap_idx) stall_bad++;
                stall_left--;
                out_ready = 1'b0;
            end else begin
                rdy = ($urandom_range(0, 99) < ready_pct);
                out_ready = rdy;
                if (out_valid && rdy) begin
                    got_data.push_back(int'($signed(out_data)));
                    got_filt.push_back(int'(out_filter));
                    got_idx.push_back(int'(out_index));
                end
            end
            if (done) begin
                done_cnt++; busy_at_done = int'(busy); fin = 1;
            end
            if (cyc >= LIMIT) begin
                timed_out = 1; fin = 1;
            end
        end
        start = 1'b0; ld_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        post_busy = int'(busy); post_done = int'(done);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy, done, out_valid} !== 3'b000) begin
            n_errors++; $display("FAIL reset_flags got=%b want=000", {busy, done, out_valid});
        end
        n_checks++;
        if ({out_data, out_filter, out_index} !== '0) begin
            n_errors++; $display("FAIL reset_outputs got=%h/%0d/%0d want=0", out_data, out_filter, out_index);
        end
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_errors++; $display("FAIL reset_idle busy got=%b want=0", busy);
        end
    endtask

    task automatic test_ones();
        for (int i = 0; i < NIMG; i++) m_img[i] = 1;
        for (int i = 0; i < NWGT; i++) m_wgt[i] = 1;
        load_mem(0);
        run_collect(100, 0, -1, -1, 0, 0, 0);
        n_checks++;
        if (got_data.size() != NWIN || timed_out != 0) begin
            n_errors++; $display("FAIL ones_count got=%0d timeout=%0d want=%0d", got_data.size(), timed_out, NWIN);
        end
        for (int i = 0; i < got_data.size(); i++) begin
            n_checks++;
            if (got_data[i] != 27 || got_filt[i] != i/8 || got_idx[i] != i%8) begin
                n_errors++;
                $display("FAIL ones_out[%0d] got=%0d f%0d i%0d want=27 f%0d i%0d",
                         i, got_data[i], got_filt[i], got_idx[i], i/8, i%8);
            end
        end
        n_checks++;
        if (first_valid != LAT) begin
            n_errors++; $display("FAIL first_valid_latency got=%0d want=%0d", first_valid, LAT);
        end
        n_checks++;
        if (done_cnt != 1 || busy_at_done != 0) begin
            n_errors++; $display("FAIL ones_done got=%0d busy=%0d want=1 busy=0", done_cnt, busy_at_done);
        end
        n_checks++;
        if (post_busy != 0 || post_done != 0) begin
            n_errors++; $display("FAIL ones_after got busy=%0d done=%0d want 0 0", post_busy, post_done);
        end
    endtask

    task automatic test_backpressure();
        run_collect(100, 10, -1, -1, 0, 0, 0);
        n_checks++;
        if (stall_samples != 10 || stall_bad != 0) begin
            n_errors++; $display("FAIL stall_stable got samples=%0d changes=%0d want 10 0", stall_samples, stall_bad);
        end
        n_checks++;
        if (snap_data != 27 || snap_idx != 0) begin
            n_errors++; $display("FAIL stall_value got=%0d idx=%0d want=27 idx=0", snap_data, snap_idx);
        end
        n_checks++;
        if (got_data.size() != NWIN || done_cnt != 1) begin
            n_errors++; $display("FAIL stall_handshakes got=%0d done=%0d want=%0d done=1", got_data.size(), done_cnt, NWIN);
        end
        for (int i = 0; i < got_data.size(); i++) begin
            n_checks++;
            if (got_data[i] != 27 || got_idx[i] != i%8) begin
                n_errors++; $display("FAIL stall_out[%0d] got=%0d i%0d want=27 i%0d", i, got_data[i], got_idx[i], i%8);
            end
        end
    endtask

    task automatic test_reset_abort();
        int dn = 0;
        start = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (99) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin
            n_errors++; $display("FAIL abort_pre_busy got=%b want=1", busy);
        end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            n_errors++; $display("FAIL abort_immediate got busy=%b valid=%b want 0 0", busy, out_valid);
        end
        repeat (3) begin
            @(negedge clk);
            if (done) dn++;
        end
        reset = 1'b0;
        @(negedge clk);
        if (done) dn++;
        n_checks++;
        if (dn != 0 || busy !== 1'b0) begin
            n_errors++; $display("FAIL abort_no_done got done_pulses=%0d busy=%b want 0 0", dn, busy);
        end
        run_collect(100, 0, 50, -1, 0, 0, 0);
        n_checks++;
        if (got_data.size() != NWIN || done_cnt != 1 || first_valid != LAT) begin
            n_errors++;
            $display("FAIL restart_run got=%0d done=%0d first=%0d want=%0d 1 %0d",
                     got_data.size(), done_cnt, first_valid, NWIN, LAT);
        end
        for (int i = 0; i < got_data.size(); i++) begin
            n_checks++;
            if (got_data[i] != 27 || got_filt[i] != i/8 || got_idx[i] != i%8) begin
                n_errors++; $display("FAIL restart_out[%0d] got=%0d f%0d i%0d want=27", i, got_data[i], got_filt[i], got_idx[i]);
            end
        end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < NIMG; i++) m_img[i] = 127;
        for (int i = 0; i < NWGT; i++) m_wgt[i] = 127;
        load_mem(0);
        run_collect(100, 0, -1, -1, 0, 0, 0);
        n_checks++;
        if (got_data.size() != NWIN) begin
            n_errors++; $display("FAIL sat_count got=%0d want=%0d", got_data.size(), NWIN);
        end
        for (int i = 0; i < got_data.size(); i++) begin
            n_checks++;
            if (got_data[i] != 32767) begin
                n_errors++; $display("FAIL sat_out[%0d] got=%0d want=32767", i, got_data[i]);
            end
        end
    endtask

    task automatic test_neg_filter();
        for (int i = 0; i < NIMG; i++) m_img[i] = 1;
        for (int i = 0; i < NWGT; i++) m_wgt[i] = (i/27 == 1) ? -1 : 1;
        load_mem(0);
        run_collect(100, 0, -1, -1, 0, 0, 0);
        n_checks++;
        if (got_data.size() != NWIN) begin
            n_errors++; $display("FAIL neg_count got=%0d want=%0d", got_data.size(), NWIN);
        end
        for (int i = 0; i < got_data.size(); i++) begin
            int want = (i/8 == 1) ? NEG27 : 27;
            n_checks++;
            if (got_data[i] != want) begin
                n_errors++; $display("FAIL neg_out[%0d] got=%0d want=%0d", i, got_data[i], want);
            end
        end
    endtask

    task automatic test_ramp();
        for (int z = 0; z < IMG; z++)
            for (int y = 0; y < IMG; y++)
                for (int x = 0; x < IMG; x++) m_img[z*IMG*IMG + y*IMG + x] = x + y + z;
        for (int i = 0; i < NWGT; i++) m_wgt[i] = (i%27 == 0) ? 1 : 0;
        load_mem(0);
        run_collect(100, 0, -1, -1, 0, 0, 0);
        n_checks++;
        if (got_data.size() != NWIN) begin
            n_errors++; $display("FAIL ramp_count got=%0d want=%0d", got_data.size(), NWIN);
        end
        for (int i = 0; i < got_data.size(); i++) begin
            int idx = i%8;
            int want = 2*(idx/4 + (idx/2)%2 + idx%2) + 3;
            n_checks++;
            if (got_data[i] != want) begin
                n_errors++; $display("FAIL ramp_out[%0d] got=%0d want=%0d", i, got_data[i], want);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < NIMG; i++) m_img[i] = int'($urandom_range(0, 255)) - 128;
        for (int i = 0; i < NWGT; i++) m_wgt[i] = int'($urandom_range(0, 40)) - 20;
        load_mem(1);
        // Out-of-range addresses must not alias onto real entries.
        @(negedge clk);
        ld_valid = 1'b1; ld_sel = 1'b1; ld_addr = 8'd200; ld_data = 8'h55;
        @(negedge clk);
        ld_sel = 1'b0; ld_addr = 8'd250; ld_data = 8'h66;
        @(negedge clk);
        ld_valid = 1'b0;
        build_expected();
        run_collect(60, 0, -1, 80, 1, NWGT-1, m_wgt[NWGT-1]);
        n_checks++;
        if (got_data.size() != NWIN || done_cnt != 1 || first_valid != LAT) begin
            n_errors++;
            $display("FAIL rand_run got=%0d done=%0d first=%0d want=%0d 1 %0d",
                     got_data.size(), done_cnt, first_valid, NWIN, LAT);
        end
        for (int i = 0; i < got_data.size() && i < NWIN; i++) begin
            n_checks++;
            if (got_data[i] != exp_data[i] || got_filt[i] != i/8 || got_idx[i] != i%8) begin
                n_errors++;
                $display("FAIL rand_out[%0d] got=%0d f%0d i%0d want=%0d f%0d i%0d",
                         i, got_data[i], got_filt[i], got_idx[i], exp_data[i], i/8, i%8);
            end
        end
    endtask

    initial begin
        reset = 1'b1; ld_valid = 1'b0; ld_sel = 1'b0; ld_addr = '0; ld_data = '0;
        start = 1'b0; out_ready = 1'b0;
        test_reset();
        test_ones();
        test_backpressure();
        test_reset_abort();
        test_saturate();
        test_neg_filter();
        test_ramp();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
